// File: rtl/cmp_arbiter.sv
// Four requesters share one 4-bit magnitude comparator through an IDLE/CMP/RSP FSM.
// Define CMP_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (0 highest).
module cmp_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] a_bus,
    input  logic [15:0] b_bus,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic        rsp_valid,
    output logic [1:0]  rsp_id,
    output logic        gt,
    output logic        eq,
    output logic        sm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  opA_q, opA_d;
    logic [3:0]  opB_q, opB_d;
    logic [1:0]  winId_q, winId_d;
    logic        rspValid_q, rspValid_d;
    logic [1:0]  rspId_q, rspId_d;
    logic        gt_q, gt_d;
    logic        eq_q, eq_d;
    logic        sm_q, sm_d;
    logic [1:0]  winner;

`ifdef CMP_ARB_RR_EN
    logic [1:0]  rrPtr_q, rrPtr_d;
    logic [1:0]  cand;

    // Scan downwards so the candidate closest to rrPtr_q+1 is written last and wins.
    always_comb begin
        winner = 2'd0;
        cand   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = rrPtr_q + 2'd1 + 2'(k);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end
`else
    always_comb begin
        winner = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                winner = 2'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = 4'b0000;
        opA_d      = opA_q;
        opB_d      = opB_q;
        winId_d    = winId_q;
        rspValid_d = 1'b0;
        rspId_d    = rspId_q;
        gt_d       = 1'b0;
        eq_d       = 1'b0;
        sm_d       = 1'b0;
`ifdef CMP_ARB_RR_EN
        rrPtr_d    = rrPtr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_d = CMP;
                    gnt_d   = 4'b0001 << winner;
                    opA_d   = a_bus[{winner, 2'b00} +: 4];
                    opB_d   = b_bus[{winner, 2'b00} +: 4];
                    winId_d = winner;
`ifdef CMP_ARB_RR_EN
                    rrPtr_d = winner;
`endif
                end
            end
            CMP: begin
                // The single shared comparator works only on the latched operands.
                state_d    = RSP;
                rspValid_d = 1'b1;
                rspId_d    = winId_q;
                gt_d       = (opA_q > opB_q);
                eq_d       = (opA_q == opB_q);
                sm_d       = (opA_q < opB_q);
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            opA_q      <= 4'd0;
            opB_q      <= 4'd0;
            winId_q    <= 2'd0;
            rspValid_q <= 1'b0;
            rspId_q    <= 2'd0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            sm_q       <= 1'b0;
`ifdef CMP_ARB_RR_EN
            rrPtr_q    <= 2'd3;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            winId_q    <= winId_d;
            rspValid_q <= rspValid_d;
            rspId_q    <= rspId_d;
            gt_q       <= gt_d;
            eq_q       <= eq_d;
            sm_q       <= sm_d;
`ifdef CMP_ARB_RR_EN
            rrPtr_q    <= rrPtr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign sm        = sm_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomized bench for cmp_arbiter against a timeline-based transaction model.
// Honours CMP_ARB_RR_EN the same way as the design when picking the expected winner.
module tb_cmp_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] aBus;
    logic [15:0] bBus;
    logic [3:0]  gnt;
    logic        busy;
    logic        rspValid;
    logic [1:0]  rspId;
    logic        gt;
    logic        eq;
    logic        sm;

    int checkCount = 0;
    int failCount  = 0;

    // Model: each grant is remembered by the edge number it happened on.
    int         edgeNo    = 0;
    int         grantEdge = -100;
    int         lastWin   = 3;
    int         winId     = 0;
    logic [1:0] expRspId  = 2'd0;
    logic [2:0] savedRes  = 3'b000;

    cmp_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_bus     (aBus),
        .b_bus     (bBus),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rspValid),
        .rsp_id    (rspId),
        .gt        (gt),
        .eq        (eq),
        .sm        (sm)
    );

    always #5 clk = ~clk;

    function automatic int pickWinner(input logic [3:0] r, input int last);
        int idx;
`ifdef CMP_ARB_RR_EN
        for (int k = 1; k <= 4; k++) begin
            idx = (last + k) % 4;
            if (r[idx]) return idx;
        end
`else
        idx = last;
        for (int k = 0; k < 4; k++) begin
            if (r[k]) return k;
        end
`endif
        return 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, observed, expected, edgeNo);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge, then check.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [15:0] a, input logic [15:0] b);
        logic [3:0] opA;
        logic [3:0] opB;
        logic [3:0] gntExp;
        logic       rspExp;
        logic       busyExp;
        logic [2:0] resExp;
        rst  = r;
        req  = rq;
        aBus = a;
        bBus = b;
        edgeNo++;
        if (r) begin
            grantEdge = -100;
            lastWin   = 3;
            expRspId  = 2'd0;
        end else if ((edgeNo - grantEdge) >= 3 && rq != 4'b0000) begin
            winId     = pickWinner(rq, lastWin);
            lastWin   = winId;
            grantEdge = edgeNo;
            opA       = a[winId*4 +: 4];
            opB       = b[winId*4 +: 4];
            savedRes  = {opA > opB, opA == opB, opA < opB};
        end
        gntExp  = (grantEdge == edgeNo) ? 4'(1 << winId) : 4'b0000;
        rspExp  = (grantEdge == edgeNo - 1);
        busyExp = (edgeNo == grantEdge) || (edgeNo == grantEdge + 1);
        resExp  = rspExp ? savedRes : 3'b000;
        if (rspExp) expRspId = 2'(winId);

        @(posedge clk);
        @(negedge clk);
        checkOutput("gnt",       32'(gnt),      32'(gntExp));
        checkOutput("busy",      32'(busy),     32'(busyExp));
        checkOutput("rsp_valid", 32'(rspValid), 32'(rspExp));
        checkOutput("rsp_id",    32'(rspId),    32'(expRspId));
        checkOutput("gt",        32'(gt),       32'(resExp[2]));
        checkOutput("eq",        32'(eq),       32'(resExp[1]));
        checkOutput("sm",        32'(sm),       32'(resExp[0]));
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  rq;
        logic        r;
        logic [3:0]  cornerA [4];
        logic [3:0]  cornerB [4];
        cornerA = '{4'd0, 4'd15, 4'd2, 4'd15};
        cornerB = '{4'd0, 4'd15, 4'd8, 4'd0};

        applyStimulus(1'b1, 4'b1111, 16'hFFFF, 16'h0000);
        applyStimulus(1'b1, 4'b1111, 16'hFFFF, 16'h0000);

        // Single request: 5 vs 3 on requester 0.
        applyStimulus(1'b0, 4'b0001, 16'h0005, 16'h0003);
        applyStimulus(1'b0, 4'b0000, 16'h0005, 16'h0003);
        applyStimulus(1'b0, 4'b0000, 16'h0005, 16'h0003);
        applyStimulus(1'b0, 4'b0000, 16'h0000, 16'h0000);

        // Operand corners on requester 2.
        for (int i = 0; i < 4; i++) begin
            a = {4'h0, cornerA[i], 8'h00};
            b = {4'h0, cornerB[i], 8'h00};
            applyStimulus(1'b0, 4'b0100, a, b);
            applyStimulus(1'b0, 4'b0000, a, b);
            applyStimulus(1'b0, 4'b0000, a, b);
        end

        // Full contention held for several grants.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 4'b1111, 16'h4321, 16'h1234);
        end
        applyStimulus(1'b0, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 4'b0000, 16'h0000, 16'h0000);

        // Busy isolation: requester 2 raises while the FSM is in CMP.
        applyStimulus(1'b0, 4'b0001, 16'h0007, 16'h0007);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b0100, 16'h0900, 16'h0300);
        end
        applyStimulus(1'b0, 4'b0000, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 4'b0000, 16'h0000, 16'h0000);

        // Operand stability: A3 drops from 6 to 1 right after the grant edge.
        applyStimulus(1'b0, 4'b1000, 16'h6000, 16'h4000);
        applyStimulus(1'b0, 4'b0000, 16'h1000, 16'h4000);
        applyStimulus(1'b0, 4'b0000, 16'h1000, 16'h4000);
        applyStimulus(1'b0, 4'b0000, 16'h1000, 16'h4000);

        // Reset while in CMP, then everyone re-raises.
        applyStimulus(1'b0, 4'b0010, 16'h00F0, 16'h0010);
        applyStimulus(1'b1, 4'b0010, 16'h00F0, 16'h0010);
        applyStimulus(1'b0, 4'b1111, 16'h1111, 16'h2222);
        applyStimulus(1'b0, 4'b0000, 16'h1111, 16'h2222);
        applyStimulus(1'b0, 4'b0000, 16'h1111, 16'h2222);

        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            rq = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0000;
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = a;
            applyStimulus(r, rq, a, b);
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
